// File: rtl/meter_display_ctrl.sv
// rtl/meter_display_ctrl.sv - parking-meter time keeping, BCD conversion and blinking 4-digit display
module meter_display_ctrl #(
   parameter int SCAN_DIV   = 100000,
   parameter int LOW_THRESH = 200,
   parameter int MAX_TIME   = 9999
) (
   input  logic        fastclk,
   input  logic        rst_n,
   input  logic        sec_tick,
   input  logic        blink_in,
   input  logic        add_req,
   input  logic [13:0] add_amt,
   output logic [13:0] time_left,
   output logic        expired,
   output logic [3:0]  an,
   output logic [6:0]  seg
);
   localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

   logic [13:0]   r_time;
   logic          r_expired;
   state_t        r_state;
   state_t        w_state_nxt;
   logic          w_start;
   logic [13:0]   r_bin;
   logic [13:0]   r_last;
   logic [15:0]   r_bcd;
   logic [15:0]   r_digits;
   logic [3:0]    r_iter;
   logic [CW-1:0] r_scan_cnt;
   logic [1:0]    r_digit_idx;
   logic [3:0]    r_an;
   logic [6:0]    r_seg;

   logic [14:0]   w_sum;
   logic [13:0]   w_base;
   logic [13:0]   w_time_nxt;
   logic [15:0]   w_adj;
   logic [3:0]    w_digit;
   logic          w_blank;

   function automatic logic [6:0] f_seg(input logic [3:0] d);
      case (d)
         4'd0:    f_seg = 7'b1000000;
         4'd1:    f_seg = 7'b1111001;
         4'd2:    f_seg = 7'b0100100;
         4'd3:    f_seg = 7'b0110000;
         4'd4:    f_seg = 7'b0011001;
         4'd5:    f_seg = 7'b0010010;
         4'd6:    f_seg = 7'b0000010;
         4'd7:    f_seg = 7'b1111000;
         4'd8:    f_seg = 7'b0000000;
         4'd9:    f_seg = 7'b0010000;
         default: f_seg = 7'b1111111;
      endcase
   endfunction

   // Saturating add happens before the tick decrement when both arrive together.
   always_comb begin
      w_sum  = {1'b0, r_time} + {1'b0, add_amt};
      w_base = r_time;
      if (add_req)
         w_base = (w_sum > 15'(MAX_TIME)) ? 14'(MAX_TIME) : w_sum[13:0];
      w_time_nxt = w_base;
      if (sec_tick)
         w_time_nxt = (w_base != 14'd0) ? w_base - 14'd1 : 14'd0;
   end

   always_ff @(posedge fastclk or negedge rst_n) begin
      if (!rst_n) begin
         r_time    <= 14'd0;
         r_expired <= 1'b1;
      end else begin
         r_time    <= w_time_nxt;
         r_expired <= (w_time_nxt == 14'd0);
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (r_time != r_last) begin
               w_state_nxt = S_SHIFT;
               w_start     = 1'b1;
            end
         end
         S_SHIFT: if (r_iter == 4'd13) w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_adj = r_bcd;
      for (int k = 0; k < 4; k++)
         if (r_bcd[k*4 +: 4] >= 4'd5) w_adj[k*4 +: 4] = r_bcd[k*4 +: 4] + 4'd3;
   end

   always_ff @(posedge fastclk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_bin    <= 14'd0;
         r_last   <= 14'd0;
         r_bcd    <= 16'd0;
         r_digits <= 16'd0;
         r_iter   <= 4'd0;
      end else begin
         r_state <= w_state_nxt;
         if (w_start) begin
            r_bin  <= r_time;
            r_last <= r_time;
            r_bcd  <= 16'd0;
            r_iter <= 4'd0;
         end else if (r_state == S_SHIFT) begin
            r_bcd  <= {w_adj[14:0], r_bin[13]};
            r_bin  <= {r_bin[12:0], 1'b0};
            r_iter <= r_iter + 4'd1;
         end else if (r_state == S_DONE) begin
            r_digits <= r_bcd;
         end
      end
   end

   always_comb begin
      case (r_digit_idx)
         2'd0:    w_digit = r_digits[3:0];
         2'd1:    w_digit = r_digits[7:4];
         2'd2:    w_digit = r_digits[11:8];
         default: w_digit = r_digits[15:12];
      endcase
      w_blank = (r_time < 14'(LOW_THRESH)) && !blink_in;
   end

   // Scan keeps running while blanked so the digit phase is undisturbed.
   always_ff @(posedge fastclk or negedge rst_n) begin
      if (!rst_n) begin
         r_scan_cnt  <= '0;
         r_digit_idx <= 2'd0;
         r_an        <= 4'b1111;
         r_seg       <= 7'b1111111;
      end else begin
         if (r_scan_cnt == CW'(SCAN_DIV - 1)) begin
            r_scan_cnt  <= '0;
            r_digit_idx <= r_digit_idx + 2'd1;
         end else begin
            r_scan_cnt <= r_scan_cnt + 1'b1;
         end
         if (w_blank) begin
            r_an  <= 4'b1111;
            r_seg <= 7'b1111111;
         end else begin
            r_an  <= ~(4'b0001 << r_digit_idx);
            r_seg <= f_seg(w_digit);
         end
      end
   end

   assign time_left = r_time;
   assign expired   = r_expired;
   assign an        = r_an;
   assign seg       = r_seg;
endmodule

// File: tb/tb_meter_display_ctrl.sv
// tb/tb_meter_display_ctrl.sv - directed scoreboard bench for meter_display_ctrl
module tb_meter_display_ctrl;
   logic        fastclk = 1'b0;
   logic        rst_n   = 1'b0;
   logic        sec_tick = 1'b0;
   logic        blink_in = 1'b1;
   logic        add_req  = 1'b0;
   logic [13:0] add_amt  = 14'd0;
   logic [13:0] time_left;
   logic        expired;
   logic [3:0]  an;
   logic [6:0]  seg;

   int errors = 0;
   int checks = 0;
   int m_time = 0;

   typedef struct packed {
      logic [3:0] an;
      logic [6:0] seg;
   } disp_t;

   logic [14:0] q_time[$];
   disp_t       q_disp[$];

   logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

   meter_display_ctrl #(.SCAN_DIV(4), .LOW_THRESH(200), .MAX_TIME(9999)) dut (
      .fastclk(fastclk), .rst_n(rst_n), .sec_tick(sec_tick), .blink_in(blink_in),
      .add_req(add_req), .add_amt(add_amt), .time_left(time_left), .expired(expired),
      .an(an), .seg(seg)
   );

   always #5 fastclk = ~fastclk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic add, input int amt, input logic tick);
      int s;
      logic [14:0] e;
      add_req  = add;
      add_amt  = 14'(amt);
      sec_tick = tick;
      s = m_time;
      if (add) s = (s + amt > 9999) ? 9999 : s + amt;
      if (tick) s = (s > 0) ? s - 1 : 0;
      m_time = s;
      q_time.push_back({(s == 0), 14'(s)});
      @(posedge fastclk); #1;
      add_req  = 1'b0;
      sec_tick = 1'b0;
      e = q_time.pop_front();
      chk("time_left", 32'(time_left), 32'(e[13:0]));
      chk("expired", 32'(expired), 32'(e[14]));
   endtask

   task automatic do_reset(input logic check_now);
      rst_n = 1'b0;
      #1;
      if (check_now) begin
         chk("rst_time_left", 32'(time_left), 32'd0);
         chk("rst_expired", 32'(expired), 32'd1);
         chk("rst_an", 32'(an), 32'hf);
         chk("rst_seg", 32'(seg), 32'h7f);
      end
      @(posedge fastclk); #1;
      rst_n  = 1'b1;
      m_time = 0;
   endtask

   task automatic check_blank(input string tag);
      @(posedge fastclk); #1;
      chk({tag, "_an"}, 32'(an), 32'hf);
      chk({tag, "_seg"}, 32'(seg), 32'h7f);
   endtask

   task automatic check_display(input int value);
      logic [3:0] prev;
      bit found;
      disp_t d;
      int p;
      repeat (40) @(posedge fastclk);
      #1;
      p = 1;
      for (int k = 0; k < 4; k++) begin
         for (int c = 0; c < 4; c++)
            q_disp.push_back({~(4'b0001 << k), seg_tab[(value / p) % 10]});
         p = p * 10;
      end
      found = 1'b0;
      prev  = an;
      for (int i = 0; i < 20 && !found; i++) begin
         @(posedge fastclk); #1;
         if (prev == 4'b0111 && an == 4'b1110) found = 1'b1;
         else prev = an;
      end
      chk("scan_align", 32'(found), 32'd1);
      if (found) begin
         for (int i = 0; i < 16; i++) begin
            if (i > 0) begin
               @(posedge fastclk); #1;
            end
            d = q_disp.pop_front();
            chk("disp_an", 32'(an), 32'(d.an));
            chk("disp_seg", 32'(seg), 32'(d.seg));
         end
      end
      q_disp.delete();
   endtask

   initial begin
      @(posedge fastclk); #1;
      do_reset(1'b1);

      step(1'b1, 125, 1'b0);
      check_display(125);
      blink_in = 1'b0;
      check_blank("blink125");
      blink_in = 1'b1;

      step(1'b1, 9865, 1'b0);
      step(1'b1, 50, 1'b0);
      blink_in = 1'b0;
      check_display(9999);

      blink_in = 1'b1;
      do_reset(1'b0);
      step(1'b1, 2, 1'b0);
      step(1'b0, 0, 1'b1);
      step(1'b0, 0, 1'b1);
      step(1'b0, 0, 1'b1);
      blink_in = 1'b0;
      check_blank("blink_expired");
      blink_in = 1'b1;
      check_display(0);

      do_reset(1'b0);
      step(1'b1, 5, 1'b0);
      step(1'b1, 10, 1'b1);

      do_reset(1'b0);
      step(1'b1, 347, 1'b0);
      check_display(347);

      step(1'b1, 100, 1'b0);
      repeat (3) @(posedge fastclk);
      #1;
      step(1'b1, 5, 1'b0);
      check_display(452);

      step(1'b1, 1000, 1'b0);
      repeat (5) @(posedge fastclk);
      #1;
      do_reset(1'b1);
      check_display(0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
